// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants.
// Used by the write-back stage and the register file.
package mips_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_mux.sv
// Write-back data select: load data or ALU result.
// Also reused as the forwarding source for EX.
module wb_mux #(
    parameter int DATA_W = mips_pkg::DATA_W
) (
    input  logic              i_sel,
    input  logic [DATA_W-1:0] i_mem,
    input  logic [DATA_W-1:0] i_alu,
    output logic [DATA_W-1:0] o_wd
);
    // A known select keeps an X on the unused input out of o_wd.
    assign o_wd = i_sel ? i_mem : i_alu;
endmodule

// File: rtl/wb_regfile.sv
// MEM/WB write-back plus 32x32 register file.
// Two combinational read ports with same-cycle write bypass.
module wb_regfile #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] RD,
    input  logic [DATA_W-1:0] ALU,
    input  logic [ADDR_W-1:0] WN,
    input  logic [ADDR_W-1:0] RN1,
    input  logic [ADDR_W-1:0] RN2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] WD,
    output logic              WE_eff
);
    import mips_pkg::*;

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] w_wd;
    logic              w_we;

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .i_sel (MemtoReg),
        .i_mem (RD),
        .i_alu (ALU),
        .o_wd  (w_wd)
    );

    assign w_we   = RegWrite && (WN != ZERO) && !rst;
    assign WE_eff = w_we;
    assign WD     = rst ? '0 : w_wd;

    // Write-before-read: a same-cycle write to the read address wins.
    function automatic logic [DATA_W-1:0] f_rd(
        input logic [ADDR_W-1:0] rn,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] v;
        v = stored;
        if (rst || rn == ZERO)
            v = '0;
        else if (w_we && rn == WN)
            v = w_wd;
        return v;
    endfunction

    assign RD1 = f_rd(RN1, r_regs[RN1]);
    assign RD2 = f_rd(RN2, r_regs[RN2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else if (w_we) begin
            r_regs[WN] <= w_wd;
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
// Inputs change on negedge; outputs sampled 1ns later or 1ns after posedge.
module tb_wb_regfile;
    logic        clk = 0;
    logic        rst;
    logic        MemtoReg;
    logic        RegWrite;
    logic [31:0] RD;
    logic [31:0] ALU;
    logic [4:0]  WN;
    logic [4:0]  RN1;
    logic [4:0]  RN2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] WD;
    logic        WE_eff;

    int checks = 0;
    int errors = 0;

    wb_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .RD       (RD),
        .ALU      (ALU),
        .WN       (WN),
        .RN1      (RN1),
        .RN2      (RN2),
        .RD1      (RD1),
        .RD2      (RD2),
        .WD       (WD),
        .WE_eff   (WE_eff)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [4:0] wn, input logic [31:0] v);
        @(negedge clk);
        RegWrite = 1;
        MemtoReg = 0;
        WN = wn;
        ALU = v;
        @(posedge clk);
        #1;
        RegWrite = 0;
    endtask

    task automatic test_reset();
        wr(5, 32'h55);
        wr(6, 32'h66);
        @(negedge clk);
        rst = 1;
        RegWrite = 1;
        WN = 5;
        ALU = 32'h77;
        RN1 = 5;
        RN2 = 6;
        #1;
        checks++;
        if (RD1 !== 0) begin
            errors++;
            $display("FAIL rst_rd1 got %h want 0", RD1);
        end
        checks++;
        if (RD2 !== 0) begin
            errors++;
            $display("FAIL rst_rd2 got %h want 0", RD2);
        end
        checks++;
        if (WD !== 0) begin
            errors++;
            $display("FAIL rst_wd got %h want 0", WD);
        end
        checks++;
        if (WE_eff !== 0) begin
            errors++;
            $display("FAIL rst_we got %b want 0", WE_eff);
        end
        @(negedge clk);
        rst = 0;
        RegWrite = 0;
        #1;
        checks++;
        if (RD1 !== 0) begin
            errors++;
            $display("FAIL rst_after_r5 got %h want 0", RD1);
        end
        checks++;
        if (RD2 !== 0) begin
            errors++;
            $display("FAIL rst_after_r6 got %h want 0", RD2);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        RegWrite = 1;
        MemtoReg = 0;
        RD = 'x;
        ALU = 32'h1234_5678;
        WN = 8;
        #1;
        checks++;
        if (WD !== 32'h1234_5678) begin
            errors++;
            $display("FAIL wd_alu_xrd got %h want 12345678", WD);
        end
        @(posedge clk);
        #1;
        RegWrite = 0;
        RN1 = 8;
        #1;
        checks++;
        if (RD1 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rd_alu got %h want 12345678", RD1);
        end
        @(negedge clk);
        RegWrite = 1;
        MemtoReg = 1;
        RD = 32'hDEAD_BEEF;
        ALU = 32'h0BAD_F00D;
        WN = 9;
        #1;
        checks++;
        if (WD !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wd_mem got %h want deadbeef", WD);
        end
        @(posedge clk);
        #1;
        RegWrite = 0;
        MemtoReg = 0;
        RN2 = 9;
        #1;
        checks++;
        if (RD2 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rd_mem got %h want deadbeef", RD2);
        end
        checks++;
        if (RD1 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rd_r8_kept got %h want 12345678", RD1);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        RN1 = 10;
        RN2 = 10;
        RegWrite = 1;
        MemtoReg = 0;
        WN = 10;
        ALU = 32'hA5A5_A5A5;
        #1;
        checks++;
        if (RD1 !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL byp_rd1 got %h want a5a5a5a5", RD1);
        end
        checks++;
        if (RD2 !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL byp_rd2 got %h want a5a5a5a5", RD2);
        end
        checks++;
        if (WE_eff !== 1) begin
            errors++;
            $display("FAIL byp_we got %b want 1", WE_eff);
        end
        @(posedge clk);
        #1;
        RegWrite = 0;
        ALU = 0;
        #1;
        checks++;
        if (RD1 !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL byp_stored got %h want a5a5a5a5", RD1);
        end
    endtask

    task automatic test_zero();
        @(negedge clk);
        RN1 = 0;
        RegWrite = 1;
        MemtoReg = 0;
        WN = 0;
        ALU = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (WE_eff !== 0) begin
            errors++;
            $display("FAIL zero_we got %b want 0", WE_eff);
        end
        checks++;
        if (RD1 !== 0) begin
            errors++;
            $display("FAIL zero_before got %h want 0", RD1);
        end
        @(posedge clk);
        #1;
        RegWrite = 0;
        #1;
        checks++;
        if (RD1 !== 0) begin
            errors++;
            $display("FAIL zero_after got %h want 0", RD1);
        end
    endtask

    task automatic test_disabled();
        wr(3, 32'd7);
        @(negedge clk);
        RN1 = 3;
        RegWrite = 0;
        MemtoReg = 0;
        WN = 3;
        ALU = 32'd99;
        #1;
        checks++;
        if (RD1 !== 32'd7) begin
            errors++;
            $display("FAIL dis_same got %0d want 7", RD1);
        end
        checks++;
        if (WE_eff !== 0) begin
            errors++;
            $display("FAIL dis_we got %b want 0", WE_eff);
        end
        checks++;
        if (WD !== 32'd99) begin
            errors++;
            $display("FAIL dis_wd got %0d want 99", WD);
        end
        @(posedge clk);
        #1;
        checks++;
        if (RD1 !== 32'd7) begin
            errors++;
            $display("FAIL dis_after got %0d want 7", RD1);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        RN1 = 4;
        for (int v = 1; v <= 3; v++) begin
            RegWrite = 1;
            MemtoReg = 0;
            WN = 4;
            ALU = v;
            #1;
            checks++;
            if (RD1 !== 32'(v)) begin
                errors++;
                $display("FAIL b2b_byp%0d got %0d want %0d", v, RD1, v);
            end
            @(negedge clk);
        end
        RegWrite = 0;
        ALU = 0;
        #1;
        checks++;
        if (RD1 !== 32'd3) begin
            errors++;
            $display("FAIL b2b_final got %0d want 3", RD1);
        end
        @(negedge clk);
        rst = 1;
        RegWrite = 1;
        WN = 4;
        ALU = 32'd5;
        @(negedge clk);
        rst = 0;
        RegWrite = 0;
        #1;
        checks++;
        if (RD1 !== 0) begin
            errors++;
            $display("FAIL b2b_rst got %0d want 0", RD1);
        end
        @(negedge clk);
        RegWrite = 1;
        ALU = 32'd6;
        @(posedge clk);
        #1;
        RegWrite = 0;
        #1;
        checks++;
        if (RD1 !== 32'd6) begin
            errors++;
            $display("FAIL b2b_post_rst got %0d want 6", RD1);
        end
    endtask

    initial begin
        rst = 1;
        MemtoReg = 0;
        RegWrite = 0;
        RD = 0;
        ALU = 0;
        WN = 0;
        RN1 = 0;
        RN2 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        test_reset();
        test_basic();
        test_bypass();
        test_zero();
        test_disabled();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
